// File: rtl/phys_reg_release_arbiter.sv
// phys_reg_release_arbiter
//   Merges physical-register releases from the commit path (source 0) and the
//   squash path (source 1) into the free list's single release port. Each
//   source has a small FIFO with a valid/ready handshake. A round-robin pick
//   feeds one registered output stage, and that stage holds its release while
//   i_list_full is high.
//
// Ports
//   i_clock, i_reset                  clock, synchronous active-high reset
//   i_commit_free_valid/_reg          commit source offer
//   o_commit_free_ready               commit FIFO has room (registered count)
//   i_squash_free_valid/_reg          squash source offer
//   o_squash_free_ready               squash FIFO has room (registered count)
//   o_reg_freed, o_freed_reg_num      release toward the free list
//   i_list_full                       free list cannot take a release this cycle
//   o_idle                            both FIFOs and the output stage are empty
//
// Configuration macro
//   REG_RELEASE_ZERO_FILTER_EN : when defined, register 0 (hard-mapped x0)
//   completes its handshake but is dropped instead of being queued.

module phys_reg_release_fifo #(
   parameter int W     = 7,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [W-1:0]     i_data,
   input  logic             i_pop,
   output logic [W-1:0]     o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_ready
);
   logic [DEPTH-1:0][W-1:0] r_mem;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;

   // Storage carries no reset; only the bookkeeping decides what is valid.
   always_ff @(posedge i_clock) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   // Registered count only: a pop on this edge does not open the FIFO early.
   assign o_ready = (r_count < CNT_W'(DEPTH));
endmodule

module phys_reg_release_arbiter #(
   parameter int REG_FILE_ADDR_WIDTH = 7,
   parameter int QUEUE_DEPTH         = 4
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_commit_free_valid,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] i_commit_free_reg,
   output logic                           o_commit_free_ready,
   input  logic                           i_squash_free_valid,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] i_squash_free_reg,
   output logic                           o_squash_free_ready,
   output logic                           o_reg_freed,
   output logic [REG_FILE_ADDR_WIDTH-1:0] o_freed_reg_num,
   input  logic                           i_list_full,
   output logic                           o_idle
);
   localparam int W     = REG_FILE_ADDR_WIDTH;
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   // Index 0 = commit, 1 = squash.
   logic [1:0]            w_valid, w_ready, w_keep, w_push, w_pop, w_nempty;
   logic [1:0][W-1:0]     w_din, w_head;
   logic [1:0][CNT_W-1:0] w_count;
   logic                  w_consume, w_load, w_sel;

   logic                  r_reg_freed;
   logic [W-1:0]          r_freed_reg_num;
   logic                  r_rr_ptr;

   assign w_valid = {i_squash_free_valid, i_commit_free_valid};
   assign w_din   = {i_squash_free_reg,   i_commit_free_reg};

`ifdef REG_RELEASE_ZERO_FILTER_EN
   // x0 is never allocated, so its release is swallowed after the handshake.
   assign w_keep = {|i_squash_free_reg, |i_commit_free_reg};
`else
   assign w_keep = 2'b11;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign w_push[gi]   = w_valid[gi] & w_ready[gi] & w_keep[gi];
         assign w_nempty[gi] = (w_count[gi] != '0);
         phys_reg_release_fifo #(.W(W), .DEPTH(QUEUE_DEPTH)) u_fifo (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_push  (w_push[gi]),
            .i_data  (w_din[gi]),
            .i_pop   (w_pop[gi]),
            .o_head  (w_head[gi]),
            .o_count (w_count[gi]),
            .o_ready (w_ready[gi])
         );
      end
   endgenerate

   assign w_consume = r_reg_freed & ~i_list_full;
   assign w_load    = (~r_reg_freed | w_consume) & (|w_nempty);

   // Contention goes to rr_ptr; otherwise whichever FIFO holds data.
   always_comb begin
      w_sel = w_nempty[1];
      if (&w_nempty) w_sel = r_rr_ptr;
   end

   assign w_pop = {w_load & w_sel, w_load & ~w_sel};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_reg_freed     <= 1'b0;
         r_freed_reg_num <= '0;
         r_rr_ptr        <= 1'b0;
      end else if (w_load) begin
         r_reg_freed     <= 1'b1;
         r_freed_reg_num <= w_head[w_sel];
         r_rr_ptr        <= ~w_sel;
      end else if (w_consume) begin
         // Number is left as-is; only the valid drops.
         r_reg_freed     <= 1'b0;
      end
   end

   assign o_commit_free_ready = w_ready[0];
   assign o_squash_free_ready = w_ready[1];
   assign o_reg_freed         = r_reg_freed;
   assign o_freed_reg_num     = r_freed_reg_num;
   assign o_idle              = (w_count[0] == '0) && (w_count[1] == '0) && !r_reg_freed;
endmodule

// File: tb/tb_phys_reg_release_arbiter.sv
module tb_phys_reg_release_arbiter;
   localparam int W = 7;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst, cv, sv, lf;
   logic [W-1:0] cr, sr;
   logic         c_rdy, s_rdy, rf, idle;
   logic [W-1:0] num;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   phys_reg_release_arbiter #(.REG_FILE_ADDR_WIDTH(W), .QUEUE_DEPTH(D)) dut (
      .i_clock             (clk),
      .i_reset             (rst),
      .i_commit_free_valid (cv),
      .i_commit_free_reg   (cr),
      .o_commit_free_ready (c_rdy),
      .i_squash_free_valid (sv),
      .i_squash_free_reg   (sr),
      .o_squash_free_ready (s_rdy),
      .o_reg_freed         (rf),
      .o_freed_reg_num     (num),
      .i_list_full         (lf),
      .o_idle              (idle)
   );

   // Reference model: two queues of pending releases plus one staged slot.
   logic [W-1:0] m_cq[$];
   logic [W-1:0] m_sq[$];
   bit           m_vld;
   logic [W-1:0] m_num;
   bit           m_rr;

   function automatic bit keep_reg(input logic [W-1:0] r);
`ifdef REG_RELEASE_ZERO_FILTER_EN
      return r != '0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step();
      bit c_ok, s_ok, free_slot, src;
      if (rst) begin
         m_cq.delete(); m_sq.delete();
         m_vld = 0; m_num = '0; m_rr = 0;
      end else begin
         c_ok = m_cq.size() < D;
         s_ok = m_sq.size() < D;
         free_slot = !m_vld || !lf;
         if (free_slot && (m_cq.size() > 0 || m_sq.size() > 0)) begin
            if (m_cq.size() > 0 && m_sq.size() > 0) src = m_rr;
            else src = (m_sq.size() > 0);
            m_num = src ? m_sq.pop_front() : m_cq.pop_front();
            m_vld = 1;
            m_rr  = !src;
         end else if (free_slot) begin
            m_vld = 0;
         end
         if (cv && c_ok && keep_reg(cr)) m_cq.push_back(cr);
         if (sv && s_ok && keep_reg(sr)) m_sq.push_back(sr);
      end
   endtask

   always @(posedge clk) model_step();

   task automatic do_reset();
      rst = 1; cv = 0; sv = 0; lf = 0; cr = '0; sr = '0;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (rf !== 1'b0) begin n_fail++; $display("FAIL reset_reg_freed got=%0b exp=0", rf); end
      n_tests++; if (num !== 7'd0) begin n_fail++; $display("FAIL reset_num got=%0d exp=0", num); end
      n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%0b exp=1", idle); end
      n_tests++; if (c_rdy !== 1'b1 || s_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b%0b exp=11", c_rdy, s_rdy); end
      // Minimum latency: accept on edge 1, visible after edge 2.
      cv = 1; cr = 7'd40;
      @(negedge clk);
      cv = 0;
      n_tests++; if (rf !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL lat_edge1 got rf=%0b idle=%0b exp rf=0 idle=0", rf, idle); end
      @(negedge clk);
      n_tests++; if (rf !== 1'b1 || num !== 7'd40) begin n_fail++; $display("FAIL lat_out got rf=%0b num=%0d exp rf=1 num=40", rf, num); end
      @(negedge clk);
      n_tests++; if (rf !== 1'b0 || idle !== 1'b1 || num !== 7'd40) begin n_fail++; $display("FAIL lat_drain got rf=%0b idle=%0b num=%0d exp 0 1 40", rf, idle, num); end
   endtask

   task automatic test_interleave();
      logic [W-1:0] exp_q[$] = '{7'd32, 7'd64, 7'd33, 7'd65, 7'd34, 7'd66};
      logic [W-1:0] got[$];
      int cyc[$];
      do_reset();
      for (int k = 0; k < 9; k++) begin
         if (k < 3) begin cv = 1; cr = 7'(32 + k); sv = 1; sr = 7'(64 + k); end
         else begin cv = 0; sv = 0; end
         @(negedge clk);
         if (rf) begin got.push_back(num); cyc.push_back(k); end
      end
      n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL ilv_count got=%0d exp=6", got.size()); end
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (i >= got.size() || got[i] !== exp_q[i] || cyc[i] != cyc[0] + i) begin
            n_fail++;
            $display("FAIL ilv_order idx=%0d got=%0d exp=%0d (back-to-back)", i, (i < got.size()) ? int'(got[i]) : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      cv = 1; cr = 7'd50;
      @(negedge clk);
      cv = 0;
      @(negedge clk);
      n_tests++; if (rf !== 1'b1 || num !== 7'd50) begin n_fail++; $display("FAIL hold_stage got rf=%0b num=%0d exp 1 50", rf, num); end
      lf = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (rf !== 1'b1 || num !== 7'd50) begin n_fail++; $display("FAIL hold_stall%0d got rf=%0b num=%0d exp 1 50", i, rf, num); end
      end
      lf = 0;
      @(negedge clk);
      n_tests++; if (rf !== 1'b0 || idle !== 1'b1 || num !== 7'd50) begin n_fail++; $display("FAIL hold_once got rf=%0b idle=%0b num=%0d exp 0 1 50", rf, idle, num); end
   endtask

   task automatic test_squash_full();
      do_reset();
      lf = 1; cv = 1; cr = 7'd50; sv = 1; sr = 7'd10;
      @(negedge clk);
      cv = 0; sr = 7'd11;
      @(negedge clk);
      sr = 7'd12;
      @(negedge clk);
      sr = 7'd13;
      @(negedge clk);
      n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL sqf_ready4 got=%0b exp=0", s_rdy); end
      sr = 7'd14;
      repeat (2) @(negedge clk);
      n_tests++; if (s_rdy !== 1'b0 || rf !== 1'b1 || num !== 7'd50) begin n_fail++; $display("FAIL sqf_held got rdy=%0b rf=%0b num=%0d exp 0 1 50", s_rdy, rf, num); end
      lf = 0;
      @(negedge clk);
      n_tests++; if (s_rdy !== 1'b1 || num !== 7'd10) begin n_fail++; $display("FAIL sqf_pop got rdy=%0b num=%0d exp 1 10", s_rdy, num); end
      @(negedge clk);
      sv = 0;
      n_tests++; if (num !== 7'd11) begin n_fail++; $display("FAIL sqf_out11 got=%0d exp=11", num); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (rf !== 1'b1 || num !== 7'(12 + i)) begin n_fail++; $display("FAIL sqf_drain%0d got rf=%0b num=%0d exp 1 %0d", i, rf, num, 12 + i); end
      end
      @(negedge clk);
      n_tests++; if (rf !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL sqf_empty got rf=%0b idle=%0b exp 0 1", rf, idle); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      lf = 1; cv = 1;
      for (int i = 0; i < 4; i++) begin cr = 7'(1 + i); @(negedge clk); end
      n_tests++; if (idle !== 1'b0 || rf !== 1'b1) begin n_fail++; $display("FAIL rmid_loaded got idle=%0b rf=%0b exp 0 1", idle, rf); end
      rst = 1; cr = 7'd9;
      @(negedge clk);
      rst = 0; cv = 0; lf = 0;
      n_tests++; if (rf !== 1'b0 || idle !== 1'b1 || num !== 7'd0) begin n_fail++; $display("FAIL rmid_clear got rf=%0b idle=%0b num=%0d exp 0 1 0", rf, idle, num); end
      n_tests++; if (c_rdy !== 1'b1 || s_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%0b%0b exp=11", c_rdy, s_rdy); end
      @(negedge clk);
      n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rmid_ignored got idle=%0b exp 1", idle); end
   endtask

   task automatic test_zero_filter();
      logic [W-1:0] got[$];
`ifdef REG_RELEASE_ZERO_FILTER_EN
      logic [W-1:0] exp_q[$] = '{7'd45};
`else
      logic [W-1:0] exp_q[$] = '{7'd0, 7'd45};
`endif
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cv = (k < 2); cr = (k == 0) ? 7'd0 : 7'd45;
         @(negedge clk);
         if (rf) got.push_back(num);
      end
      n_tests++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_count got=%0d exp=%0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL zero_val idx=%0d got=%0d exp=%0d", i, (i < got.size()) ? int'(got[i]) : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         n_tests++; if (rf !== m_vld) begin n_fail++; $display("FAIL rnd_rf cyc=%0d got=%0b exp=%0b", k, rf, m_vld); end
         n_tests++; if (num !== m_num) begin n_fail++; $display("FAIL rnd_num cyc=%0d got=%0d exp=%0d", k, num, m_num); end
         n_tests++; if (c_rdy !== (m_cq.size() < D) || s_rdy !== (m_sq.size() < D)) begin
            n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b%0b exp=%0b%0b", k, c_rdy, s_rdy, m_cq.size() < D, m_sq.size() < D);
         end
         n_tests++; if (idle !== (m_cq.size() == 0 && m_sq.size() == 0 && !m_vld)) begin n_fail++; $display("FAIL rnd_idle cyc=%0d got=%0b", k, idle); end
         rst = ($urandom_range(0, 63) == 0);
         lf  = ($urandom_range(0, 3) == 0);
         cv  = ($urandom_range(0, 9) < 7);
         sv  = ($urandom_range(0, 9) < 6);
         cr  = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         sr  = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         @(negedge clk);
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_interleave();
      test_hold();
      test_squash_full();
      test_reset_mid();
      test_zero_filter();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
